aes_ctr_stream: RTL and testbench

Counter-mode (CTR) front/back end for the `AES_128` core. It turns a stream of 128-bit plaintext blocks into ciphertext. It generates counter blocks of the form `{nonce, ctr}`, drives them with the key into the core, and XORs the core's registered keystream with the matching plaintext block. It sits directly around `AES_128`: its outputs feed the core's `state` and `key` inputs, and it consumes the core's `out`. It owns all flow control, since the core itself has no enable or valid.

---
 rtl/aes_pkg.sv | 8 +
 rtl/aes_128.sv | 83 ++++++++
 rtl/aes_ctr_counter.sv | 36 +++
 rtl/aes_ctr_stream.sv | 86 ++++++++
 tb/tb_aes_ctr_stream.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared widths and block type for the AES-128 CTR datapath.
package aes_pkg;
  localparam int AES_BLK_W   = 128;
  localparam int AES_NR      = 10;
  localparam int CTR_NONCE_W = 96;

  typedef logic [AES_BLK_W-1:0] aes_blk_t;
endpackage

// File: rtl/aes_128.sv
// Single-cycle AES-128 encryption core: combinational 10 rounds, output registered one cycle after state/key.
// No reset and no enable; the CTR wrapper holds state/key steady when the result must be held.
module AES_128 import aes_pkg::*; (
  input  logic     clk,
  input  aes_blk_t state,
  input  aes_blk_t key,
  output aes_blk_t out
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte i of a block is bits [127-8i -: 8], at row i%4, column i/4.
  function automatic aes_blk_t sub_shift(input aes_blk_t s);
    aes_blk_t o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(4*c + r) -: 8] = sbox(s[127 - 8*(4*((c + r) % 4) + r) -: 8]);
    return o;
  endfunction

  function automatic aes_blk_t mix_cols(input aes_blk_t s);
    aes_blk_t o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127 - 32*c -: 32];
      o[127 - 32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                             a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                             a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                             xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o;
  endfunction

  function automatic aes_blk_t key_step(input aes_blk_t k, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64]  ^ w0;
    w2 = k[63:32]  ^ w1;
    w3 = k[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  aes_blk_t   st;
  aes_blk_t   rk;
  logic [7:0] rc;

  always_comb begin
    rk = key;
    st = state ^ key;
    rc = 8'h01;
    for (int r = 1; r <= AES_NR; r++) begin
      rk = key_step(rk, rc);
      rc = xtime(rc);
      st = (r == AES_NR) ? sub_shift(st) : mix_cols(sub_shift(st));
      st = st ^ rk;
    end
  end

  always_ff @(posedge clk) begin
    out <= st;
  end

endmodule

// File: rtl/aes_ctr_counter.sv
// CTR counter: next counter, counter of the block in the output stage, wrap detect, core state mux.
// While no block is accepted the held counter is replayed so the core output stays stable.
module aes_ctr_counter import aes_pkg::*; #(
  parameter int NONCE_W = CTR_NONCE_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load,
  input  logic [AES_BLK_W-NONCE_W-1:0] load_ctr,
  input  logic                         accept,
  input  logic [NONCE_W-1:0]           nonce,
  output aes_blk_t                     state,
  output logic                         wrap_hit
);

  localparam int CTR_W = AES_BLK_W - NONCE_W;

  logic [CTR_W-1:0] ctr_q;
  logic [CTR_W-1:0] ctr_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      ctr_q    <= '0;
      ctr_hold <= '0;
    end else if (load) begin
      ctr_q <= load_ctr;
    end else if (accept) begin
      ctr_q    <= ctr_q + CTR_W'(1);
      ctr_hold <= ctr_q;
    end
  end

  assign wrap_hit = accept && (&ctr_q);
  assign state    = accept ? {nonce, ctr_q} : {nonce, ctr_hold};

endmodule

// File: rtl/aes_ctr_stream.sv
// AES-128 CTR stream wrapper: block accepted at one edge appears on out_* the next cycle, 1 block/clock.
// in_ready drops combinationally on out stall or pending config; out_data holds while stalled.
module aes_ctr_stream import aes_pkg::*; #(
  parameter int NONCE_W = CTR_NONCE_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  aes_blk_t                     cfg_key,
  input  logic [NONCE_W-1:0]           cfg_nonce,
  input  logic [AES_BLK_W-NONCE_W-1:0] cfg_ctr,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  aes_blk_t                     in_data,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output aes_blk_t                     out_data,
  output logic                         out_last,
  output aes_blk_t                     aes_key,
  output aes_blk_t                     aes_state,
  input  aes_blk_t                     aes_out,
  output logic                         ctr_wrap
);

  aes_blk_t           key_q;
  logic [NONCE_W-1:0] nonce_q;
  aes_blk_t           pt_q;
  logic               last_q;
  logic               cfg_done;
  logic               cfg_acc;
  logic               accept;
  logic               out_xfer;
  logic               wrap_hit;

  assign cfg_ready = !out_valid;
  assign cfg_acc   = cfg_valid && cfg_ready;
  // Config wins over data in the same cycle so a new key never pairs with a stale counter.
  assign in_ready  = cfg_done && !ctr_wrap && !cfg_valid && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  aes_ctr_counter #(.NONCE_W(NONCE_W)) u_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (cfg_acc),
    .load_ctr (cfg_ctr),
    .accept   (accept),
    .nonce    (nonce_q),
    .state    (aes_state),
    .wrap_hit (wrap_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q     <= '0;
      nonce_q   <= '0;
      pt_q      <= '0;
      last_q    <= 1'b0;
      out_valid <= 1'b0;
      ctr_wrap  <= 1'b0;
      cfg_done  <= 1'b0;
    end else begin
      if (cfg_acc) begin
        key_q    <= cfg_key;
        nonce_q  <= cfg_nonce;
        cfg_done <= 1'b1;
        ctr_wrap <= 1'b0;
      end
      if (accept) begin
        pt_q      <= in_data;
        last_q    <= in_last;
        out_valid <= 1'b1;
        if (wrap_hit) ctr_wrap <= 1'b1;
      end else if (out_xfer) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign aes_key  = key_q;
  assign out_data = pt_q ^ aes_out;
  assign out_last = last_q;

endmodule

// File: tb/tb_aes_ctr_stream.sv
// Bench for aes_ctr_stream around AES_128, with an independent AES reference and ciphertext scoreboard.
module tb_aes_ctr_stream;
  import aes_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, cfg_valid, cfg_ready, in_valid, in_ready, in_last;
  logic out_valid, out_ready, out_last, ctr_wrap;
  logic [127:0] cfg_key, in_data, out_data, aes_key, aes_state, aes_out;
  logic [95:0]  cfg_nonce;
  logic [31:0]  cfg_ctr;

  aes_ctr_stream #(.NONCE_W(96)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_key(cfg_key), .cfg_nonce(cfg_nonce), .cfg_ctr(cfg_ctr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .aes_key(aes_key), .aes_state(aes_state), .aes_out(aes_out), .ctr_wrap(ctr_wrap)
  );

  AES_128 u_aes (.clk(clk), .state(aes_state), .key(aes_key), .out(aes_out));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed { logic [127:0] data; logic last; } exp_t;
  exp_t q[$];

  // Reference AES: S-box built algebraically (GF(2^8) inverse + affine map).
  logic [7:0] sb [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] calc_sbox(input logic [7:0] a);
    logic [7:0] v;
    v = 8'h01;
    for (int i = 0; i < 254; i++) v = gmul(v, a);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] ref_aes(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0]  s [4][4];
    logic [7:0]  t [4][4];
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = pt[127 - 8*(4*c + r) -: 8] ^ w[c][31 - 8*r -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][c] = sb[s[r][(c + r) % 4]];
      for (int c = 0; c < 4; c++) begin
        if (rnd < 10) begin
          s[0][c] = gmul(t[0][c], 8'h02) ^ gmul(t[1][c], 8'h03) ^ t[2][c] ^ t[3][c];
          s[1][c] = t[0][c] ^ gmul(t[1][c], 8'h02) ^ gmul(t[2][c], 8'h03) ^ t[3][c];
          s[2][c] = t[0][c] ^ t[1][c] ^ gmul(t[2][c], 8'h02) ^ gmul(t[3][c], 8'h03);
          s[3][c] = gmul(t[0][c], 8'h03) ^ t[1][c] ^ t[2][c] ^ gmul(t[3][c], 8'h02);
        end else begin
          for (int r = 0; r < 4; r++) s[r][c] = t[r][c];
        end
        for (int r = 0; r < 4; r++) s[r][c] = s[r][c] ^ w[4*rnd + c][31 - 8*r -: 8];
      end
    end
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127 - 8*(4*c + r) -: 8] = s[r][c];
    return res;
  endfunction

  // Cycle model of the wrapper, advanced at each falling edge for the coming rising edge.
  logic [127:0] m_key;
  logic [95:0]  m_nonce;
  logic [31:0]  m_ctr;
  logic m_ov, m_cfg_done, m_wrap, exp_in_rdy, exp_cfg_rdy, m_acc, m_xfer;
  bit   mon_en = 1'b0;
  exp_t e;

  always @(negedge clk) begin
    if (mon_en) begin
      exp_cfg_rdy = !m_ov;
      exp_in_rdy  = m_cfg_done && !m_wrap && !cfg_valid && (!m_ov || out_ready);
      n_checks++; if (out_valid !== m_ov) begin n_fail++; $display("FAIL mon_out_valid: got %b want %b at %0t", out_valid, m_ov, $time); end
      n_checks++; if (in_ready !== exp_in_rdy) begin n_fail++; $display("FAIL mon_in_ready: got %b want %b at %0t", in_ready, exp_in_rdy, $time); end
      n_checks++; if (cfg_ready !== exp_cfg_rdy) begin n_fail++; $display("FAIL mon_cfg_ready: got %b want %b at %0t", cfg_ready, exp_cfg_rdy, $time); end
      n_checks++; if (ctr_wrap !== m_wrap) begin n_fail++; $display("FAIL mon_ctr_wrap: got %b want %b at %0t", ctr_wrap, m_wrap, $time); end
      n_checks++; if (aes_key !== m_key) begin n_fail++; $display("FAIL mon_aes_key: got %h want %h", aes_key, m_key); end
      if (rst) begin
        m_ov = 0; m_cfg_done = 0; m_wrap = 0; m_key = '0; m_nonce = '0; m_ctr = '0;
        q.delete();
      end else begin
        m_xfer = m_ov && out_ready;
        m_acc  = in_valid && exp_in_rdy;
        if (m_xfer) begin
          n_checks++;
          if (q.size() == 0) begin
            n_fail++; $display("FAIL sb_empty: output transfer with no block expected at %0t", $time);
          end else begin
            e = q.pop_front();
            if (out_data !== e.data || out_last !== e.last) begin
              n_fail++; $display("FAIL sb_data: got %h/%b want %h/%b at %0t", out_data, out_last, e.data, e.last, $time);
            end
          end
        end
        if (cfg_valid && exp_cfg_rdy) begin
          m_key = cfg_key; m_nonce = cfg_nonce; m_ctr = cfg_ctr; m_cfg_done = 1; m_wrap = 0;
        end
        if (m_acc) begin
          q.push_back('{data: in_data ^ ref_aes(m_key, {m_nonce, m_ctr}), last: in_last});
          if (&m_ctr) m_wrap = 1;
          m_ctr = m_ctr + 32'd1;
          m_ov  = 1;
        end else if (m_xfer) begin
          m_ov = 0;
        end
      end
    end
  end

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_cfg(input logic [127:0] k, input logic [95:0] n, input logic [31:0] c);
    bit done;
    done = 0;
    cfg_key = k; cfg_nonce = n; cfg_ctr = c; cfg_valid = 1;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      done = (cfg_ready === 1'b1);
      @(posedge clk); #1;
    end
    cfg_valid = 0;
    n_checks++;
    if (!done) begin n_fail++; $display("FAIL cfg_timeout: cfg_ready got 0 want 1 within 50 cycles"); end
  endtask

  task automatic send(input logic [127:0] d, input logic l, output int waited);
    in_valid = 1; in_data = d; in_last = l; waited = 0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin @(posedge clk); #1; return; end
      waited++;
      @(posedge clk); #1;
    end
    n_checks++; n_fail++;
    $display("FAIL send_timeout: in_ready got 0 want 1 within 50 cycles");
  endtask

  task automatic test_reset();
    in_valid = 1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_checks++; if (ctr_wrap !== 1'b0) begin n_fail++; $display("FAIL rst_ctr_wrap: got %b want 0", ctr_wrap); end
    n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL rst_cfg_ready: got %b want 1", cfg_ready); end
    n_checks++; if (aes_state !== 128'h0) begin n_fail++; $display("FAIL rst_aes_state: got %h want 0", aes_state); end
    repeat (3) begin
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
      @(posedge clk); #1;
    end
    in_valid = 0;
  endtask

  task automatic test_fips();
    do_cfg(128'h000102030405060708090a0b0c0d0e0f, 96'h00112233445566778899aabb, 32'hccddeeff);
    out_ready = 0; in_valid = 1; in_data = '0; in_last = 1;
    @(negedge clk);
    n_checks++; if (aes_state !== 128'h00112233445566778899aabbccddeeff) begin n_fail++; $display("FAIL fips_state: got %h want 00112233445566778899aabbccddeeff", aes_state); end
    @(posedge clk); #1;
    in_valid = 0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL fips_valid: got %b want 1", out_valid); end
    n_checks++; if (out_data !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin n_fail++; $display("FAIL fips_data: got %h want 69c4e0d86a7b0430d8cdb78070b4c55a", out_data); end
    @(posedge clk); #1;
    n_checks++; if (out_data !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin n_fail++; $display("FAIL fips_hold: got %h want 69c4e0d86a7b0430d8cdb78070b4c55a", out_data); end
    out_ready = 1;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fips_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_streaming();
    int w;
    do_cfg(rnd128(), 96'hcafef00d_12345678_9abcdef0, 32'h0000_fffc);
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      send(rnd128(), i == 7, w);
      n_checks++; if (w !== 0) begin n_fail++; $display("FAIL stream_stall: block %0d waited %0d want 0", i, w); end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid: block %0d got %b want 1", i, out_valid); end
    end
    in_valid = 0;
    n_checks++; if (out_last !== 1'b1) begin n_fail++; $display("FAIL stream_last: got %b want 1", out_last); end
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain: got %b want 0", out_valid); end
    n_checks++; if (q.size() !== 0) begin n_fail++; $display("FAIL stream_left: got %0d want 0", q.size()); end
  endtask

  task automatic test_backpressure();
    int sent;
    logic ok;
    logic [127:0] held;
    sent = 0; held = '0;
    do_cfg(rnd128(), 96'h0a0b0c0d_0e0f1011_12131415, 32'h7fff_fffe);
    in_valid = 1; in_data = rnd128(); in_last = 0;
    for (int c = 0; c < 40 && (sent < 10 || out_valid === 1'b1); c++) begin
      out_ready = !(c >= 3 && c < 8);
      @(negedge clk);
      if (c >= 3 && c < 8) begin
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: cycle %0d got %b want 0", c, in_ready); end
        if (c == 3) held = out_data;
        else begin
          n_checks++; if (out_data !== held) begin n_fail++; $display("FAIL bp_hold: cycle %0d got %h want %h", c, out_data, held); end
        end
      end
      ok = in_valid && in_ready;
      @(posedge clk); #1;
      if (ok) begin
        sent++;
        in_data = rnd128(); in_last = (sent == 9);
        if (sent == 10) in_valid = 0;
      end
    end
    in_valid = 0; out_ready = 1;
    n_checks++; if (sent !== 10) begin n_fail++; $display("FAIL bp_sent: got %0d want 10", sent); end
    n_checks++; if (q.size() !== 0) begin n_fail++; $display("FAIL bp_left: got %0d want 0", q.size()); end
  endtask

  task automatic test_wrap();
    int w;
    logic [127:0] k;
    k = rnd128();
    out_ready = 1;
    do_cfg(k, 96'h55aa55aa_55aa55aa_55aa55aa, 32'hffff_ffff);
    send(rnd128(), 0, w);
    in_data = rnd128();
    n_checks++; if (ctr_wrap !== 1'b1) begin n_fail++; $display("FAIL wrap_flag: got %b want 1", ctr_wrap); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL wrap_block: got %b want 0", in_ready); end
    repeat (4) begin
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL wrap_hold: in_ready got %b want 0", in_ready); end
      @(posedge clk); #1;
    end
    in_valid = 0;
    do_cfg(k, 96'h55aa55aa_55aa55aa_55aa55aa, 32'h0000_0010);
    n_checks++; if (ctr_wrap !== 1'b0) begin n_fail++; $display("FAIL wrap_clear: got %b want 0", ctr_wrap); end
    send(rnd128(), 0, w);
    send(rnd128(), 1, w);
    in_valid = 0;
    repeat (2) begin @(posedge clk); #1; end
    n_checks++; if (q.size() !== 0) begin n_fail++; $display("FAIL wrap_left: got %0d want 0", q.size()); end
  endtask

  task automatic test_config();
    int w;
    out_ready = 0;
    send(rnd128(), 0, w);
    in_valid = 0;
    cfg_valid = 1; cfg_key = rnd128(); cfg_nonce = 96'h01020304_05060708_090a0b0c; cfg_ctr = 32'h0000_0100;
    in_valid = 1; in_data = rnd128(); in_last = 1;
    repeat (3) begin
      @(negedge clk);
      n_checks++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL cfg_stall: cfg_ready got %b want 0", cfg_ready); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL cfg_in_block: in_ready got %b want 0", in_ready); end
      @(posedge clk); #1;
    end
    out_ready = 1;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL cfg_take: cfg_ready got %b want 1", cfg_ready); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL cfg_priority: in_ready got %b want 0", in_ready); end
    @(posedge clk); #1;
    cfg_valid = 0;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL cfg_after: in_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk); #1;
    n_checks++; if (q.size() !== 0) begin n_fail++; $display("FAIL cfg_left: got %0d want 0", q.size()); end
  endtask

  task automatic test_reset_midstream();
    int w;
    do_cfg(rnd128(), 96'hdeadbeef_00000000_feedface, 32'h0000_0042);
    out_ready = 0;
    send(rnd128(), 0, w);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre: out_valid got %b want 1", out_valid); end
    rst = 1;
    @(posedge clk); #1;
    rst = 0; out_ready = 1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_in_ready: got %b want 0", in_ready); end
    repeat (3) begin
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_noconfig: in_ready got %b want 0", in_ready); end
      @(posedge clk); #1;
    end
    in_valid = 0;
    do_cfg(rnd128(), 96'h11111111_22222222_33333333, 32'h0000_0000);
    send(rnd128(), 1, w);
    in_valid = 0;
    repeat (2) begin @(posedge clk); #1; end
    n_checks++; if (q.size() !== 0) begin n_fail++; $display("FAIL mid_left: got %0d want 0", q.size()); end
  endtask

  initial begin
    rst = 1; cfg_valid = 0; cfg_key = '0; cfg_nonce = '0; cfg_ctr = '0;
    in_valid = 0; in_data = '0; in_last = 0; out_ready = 1;
    for (int i = 0; i < 256; i++) sb[i] = calc_sbox(8'(i));
    repeat (2) @(posedge clk);
    #1;
    m_ov = 0; m_cfg_done = 0; m_wrap = 0; m_key = '0; m_nonce = '0; m_ctr = '0;
    mon_en = 1;
    rst = 0;
    test_reset();
    test_fips();
    test_streaming();
    test_backpressure();
    test_wrap();
    test_config();
    test_reset_midstream();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
